// File: rtl/traffic_analyzer_pkg.sv
// Shared constants for the GMII traffic analyzer receive path: FSM states,
// frame classes, framing bytes, CRC-32 constants and counter indices.
package traffic_analyzer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_FRAME    = 2'd2,
    ST_VERDICT  = 2'd3
  } rx_state_e;

  localparam logic [1:0] FC_GOOD     = 2'd0;
  localparam logic [1:0] FC_CRC_ERR  = 2'd1;
  localparam logic [1:0] FC_LEN_ERR  = 2'd2;
  localparam logic [1:0] FC_GMII_ERR = 2'd3;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hd5;

  // Reflected CRC-32; running register over data+FCS ends at this residue.
  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  localparam int NUM_CNT   = 6;
  localparam int CI_TOTAL  = 0;
  localparam int CI_GOOD   = 1;
  localparam int CI_CRC    = 2;
  localparam int CI_LEN    = 3;
  localparam int CI_GMII   = 4;
  localparam int CI_BYTES  = 5;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++)
      c = (c[0] ^ b[i]) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    return c;
  endfunction

endpackage

// File: rtl/ethernet_crc_8_check.sv
// Byte-wide Ethernet FCS checker. Starts at the SFD, and when RX_DV drops
// latches whether the frame (FCS included) hit the CRC-32 residue.
module ethernet_crc_8_check
  import traffic_analyzer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] d,
  input  logic       en,
  input  logic       er,
  output logic       crc_ok
);

  logic        in_frame;
  logic        err;
  logic [31:0] crc;

  // crc_ok holds its value until the next frame ends, so a reader one cycle
  // after RX_DV drops sees this frame's verdict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_frame <= 1'b0;
      err      <= 1'b0;
      crc      <= '1;
      crc_ok   <= 1'b0;
    end else if (!en) begin
      if (in_frame) crc_ok <= (crc == CRC_RESIDUE) && !err;
      in_frame <= 1'b0;
    end else if (!in_frame) begin
      if (d == SFD_BYTE) begin
        in_frame <= 1'b1;
        err      <= 1'b0;
        crc      <= '1;
      end
    end else begin
      crc <= crc32_byte(crc, d);
      if (er) err <= 1'b1;
    end
  end

endmodule

// File: rtl/gmii_rx_frame_stats.sv
// GMII receive frame sequencer: delimits frames, classifies them using the
// CRC checker verdict, and keeps saturating statistics with snapshot readout.
module gmii_rx_frame_stats
  import traffic_analyzer_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [7:0]       d,
  input  logic             en,
  input  logic             er,
  input  logic             snap_req,
  input  logic             snap_clear,
  output logic             snap_ack,
  output logic             frame_done,
  output logic [1:0]       frame_class,
  output logic [15:0]      frame_len,
  output logic [CNT_W-1:0] snap_total,
  output logic [CNT_W-1:0] snap_good,
  output logic [CNT_W-1:0] snap_crc_err,
  output logic [CNT_W-1:0] snap_len_err,
  output logic [CNT_W-1:0] snap_gmii_err,
  output logic [CNT_W-1:0] snap_good_bytes
);

  localparam logic [15:0] MIN_L = 16'(MIN_LEN);
  localparam logic [15:0] MAX_L = 16'(MAX_LEN);

  rx_state_e   state, state_nxt;
  logic [15:0] len;
  logic        gerr;
  logic        crc_ok;
  logic [1:0]  cls;
  logic [NUM_CNT-1:0][CNT_W-1:0] inc;
  logic [NUM_CNT-1:0][CNT_W-1:0] snap;

  ethernet_crc_8_check u_crc (
    .clk    (clk),
    .rst    (~resetn),
    .d      (d),
    .en     (en),
    .er     (er),
    .crc_ok (crc_ok)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:     if (en && d == PREAMBLE_BYTE) state_nxt = ST_PREAMBLE;
      ST_PREAMBLE: begin
        if (!en)                   state_nxt = ST_IDLE;
        else if (d == SFD_BYTE)    state_nxt = ST_FRAME;
        else if (d != PREAMBLE_BYTE) state_nxt = ST_IDLE;
      end
      ST_FRAME:    if (!en) state_nxt = ST_VERDICT;
      // A preamble byte right after the gap starts the next frame here.
      ST_VERDICT:  state_nxt = (en && d == PREAMBLE_BYTE) ? ST_PREAMBLE : ST_IDLE;
    endcase
  end

  always_comb begin
    cls = FC_GOOD;
    if (gerr)                          cls = FC_GMII_ERR;
    else if (len < MIN_L || len > MAX_L) cls = FC_LEN_ERR;
    else if (!crc_ok)                  cls = FC_CRC_ERR;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      len  <= '0;
      gerr <= 1'b0;
    end else if (state == ST_PREAMBLE && en && d == SFD_BYTE) begin
      len  <= '0;
      gerr <= 1'b0;
    end else if (state == ST_FRAME && en) begin
      if (len != 16'hFFFF) len <= len + 16'd1;
      if (er) gerr <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frame_done  <= 1'b0;
      frame_class <= FC_GOOD;
      frame_len   <= '0;
      snap_ack    <= 1'b0;
    end else begin
      frame_done <= (state == ST_VERDICT);
      snap_ack   <= snap_req;
      if (state == ST_VERDICT) begin
        frame_class <= cls;
        frame_len   <= len;
      end
    end
  end

  always_comb begin
    inc = '0;
    if (state == ST_VERDICT) begin
      inc[CI_TOTAL] = CNT_W'(1);
      unique case (cls)
        FC_GOOD:     inc[CI_GOOD] = CNT_W'(1);
        FC_CRC_ERR:  inc[CI_CRC]  = CNT_W'(1);
        FC_LEN_ERR:  inc[CI_LEN]  = CNT_W'(1);
        FC_GMII_ERR: inc[CI_GMII] = CNT_W'(1);
      endcase
      if (cls == FC_GOOD) inc[CI_BYTES] = CNT_W'(len);
    end
  end

  // Clearing loads the concurrent increment so a frame finishing on the
  // snapshot edge lands in the new interval rather than being dropped.
  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    logic [CNT_W-1:0] live_q, snap_q;
    logic [CNT_W:0]   sum;

    assign sum = {1'b0, live_q} + {1'b0, inc[i]};

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        live_q <= '0;
        snap_q <= '0;
      end else begin
        if (snap_req) snap_q <= live_q;
        if (snap_req && snap_clear) live_q <= inc[i];
        else                        live_q <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
      end
    end

    assign snap[i] = snap_q;
  end

  assign snap_total      = snap[CI_TOTAL];
  assign snap_good       = snap[CI_GOOD];
  assign snap_crc_err    = snap[CI_CRC];
  assign snap_len_err    = snap[CI_LEN];
  assign snap_gmii_err   = snap[CI_GMII];
  assign snap_good_bytes = snap[CI_BYTES];

endmodule

// File: tb/tb_gmii_rx_frame_stats.sv
// Directed bench for gmii_rx_frame_stats: frame classes, counter snapshots,
// back-to-back frames with snapshot-clear collision, and mid-frame reset.
module tb_gmii_rx_frame_stats;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  d = '0;
  logic        en = 1'b0, er = 1'b0, snap_req = 1'b0, snap_clear = 1'b0;
  logic        snap_ack, frame_done;
  logic [1:0]  frame_class;
  logic [15:0] frame_len;
  logic [31:0] snap_total, snap_good, snap_crc_err, snap_len_err, snap_gmii_err, snap_good_bytes;

  int nchk = 0;
  int nfail = 0;
  logic [7:0] fq[$];

  gmii_rx_frame_stats #(.CNT_W(32), .MIN_LEN(64), .MAX_LEN(1518)) dut (
    .clk(clk), .resetn(resetn), .d(d), .en(en), .er(er),
    .snap_req(snap_req), .snap_clear(snap_clear), .snap_ack(snap_ack),
    .frame_done(frame_done), .frame_class(frame_class), .frame_len(frame_len),
    .snap_total(snap_total), .snap_good(snap_good), .snap_crc_err(snap_crc_err),
    .snap_len_err(snap_len_err), .snap_gmii_err(snap_gmii_err),
    .snap_good_bytes(snap_good_bytes)
  );

  always #4 clk = ~clk;

  function automatic logic [31:0] crc_upd(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++)
      c = (c[0] ^ b[i]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Frame body: ndata payload bytes then FCS (LSB first), optional last-byte flip.
  task automatic build(input int ndata, input logic bad_fcs);
    logic [31:0] c;
    logic [7:0]  b;
    fq.delete();
    c = '1;
    for (int i = 0; i < ndata; i++) begin
      b = 8'(i * 7 + 3);
      fq.push_back(b);
      c = crc_upd(c, b);
    end
    c = ~c;
    for (int k = 0; k < 4; k++) fq.push_back(c[8*k +: 8]);
    if (bad_fcs) fq[fq.size()-1] = fq[fq.size()-1] ^ 8'h01;
  endtask

  task automatic cyc(input logic [7:0] dv, input logic ev, input logic erv,
                     input logic sr, input logic sc);
    @(negedge clk);
    d = dv; en = ev; er = erv; snap_req = sr; snap_clear = sc;
  endtask

  task automatic send_body(input int er_idx);
    cyc(8'hd5, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < fq.size(); i++) cyc(fq[i], 1'b1, i == er_idx, 1'b0, 1'b0);
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send(input int er_idx);
    for (int i = 0; i < 7; i++) cyc(8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    send_body(er_idx);
  endtask

  task automatic expect_frame(input string tag, input int cls, input int len);
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk({tag, "_done_t1"}, 32'(frame_done), 0);
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk({tag, "_done_t2"}, 32'(frame_done), 1);
    chk({tag, "_class"}, 32'(frame_class), cls);
    chk({tag, "_len"}, 32'(frame_len), len);
  endtask

  task automatic snap(input string tag, input logic clr, input int tot, input int gd,
                      input int ce, input int le, input int ge, input int by);
    cyc(8'h00, 1'b0, 1'b0, 1'b1, clr);
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk({tag, "_ack"}, 32'(snap_ack), 1);
    chk({tag, "_total"}, snap_total, tot);
    chk({tag, "_good"}, snap_good, gd);
    chk({tag, "_crc"}, snap_crc_err, ce);
    chk({tag, "_len"}, snap_len_err, le);
    chk({tag, "_gmii"}, snap_gmii_err, ge);
    chk({tag, "_bytes"}, snap_good_bytes, by);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(snap_ack), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_class", 32'(frame_class), 0);
    chk("rst_len", 32'(frame_len), 0);
    chk("rst_total", snap_total, 0);
    chk("rst_bytes", snap_good_bytes, 0);
    resetn = 1'b1;
    repeat (2) cyc(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // 64-byte good frame
    build(60, 1'b0); send(-1); expect_frame("good64", 0, 64);
    snap("s1", 1'b0, 1, 1, 0, 0, 0, 64);

    // FCS corrupted
    build(60, 1'b1); send(-1); expect_frame("crc64", 1, 64);
    snap("s2", 1'b0, 2, 1, 1, 0, 0, 64);

    // length boundaries
    build(56, 1'b0); send(-1); expect_frame("short60", 2, 60);
    build(1515, 1'b0); send(-1); expect_frame("long1519", 2, 1519);
    build(1514, 1'b0); send(-1); expect_frame("max1518", 0, 1518);

    // RX_ER mid-frame with a valid FCS
    build(60, 1'b0); send(20); expect_frame("gmii", 3, 64);
    snap("s3", 1'b1, 6, 2, 1, 2, 1, 64 + 1518);
    snap("s4", 1'b0, 0, 0, 0, 0, 0, 0);

    // back-to-back with a 1-cycle gap; clear snapshot lands on 2nd verdict edge
    build(60, 1'b0); send(-1);
    cyc(8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("b2b_a_t1", 32'(frame_done), 0);
    cyc(8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("b2b_a_done", 32'(frame_done), 1);
    chk("b2b_a_class", 32'(frame_class), 0);
    for (int i = 0; i < 5; i++) cyc(8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    send_body(-1);
    cyc(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("b2b_b_done", 32'(frame_done), 1);
    chk("b2b_b_class", 32'(frame_class), 0);
    chk("b2b_snap_ack", 32'(snap_ack), 1);
    chk("b2b_snap_total", snap_total, 1);
    chk("b2b_snap_bytes", snap_good_bytes, 64);
    snap("s5", 1'b0, 1, 1, 0, 0, 0, 64);

    // back-to-back snapshot requests
    cyc(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("dbl_ack1", 32'(snap_ack), 1);
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("dbl_ack2", 32'(snap_ack), 1);
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("dbl_ack3", 32'(snap_ack), 0);

    // reset mid-payload
    build(60, 1'b0);
    for (int i = 0; i < 7; i++) cyc(8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(8'hd5, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(fq[i], 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); resetn = 1'b0; d = 8'h00;
    @(negedge clk);
    chk("mrst_total", snap_total, 0);
    chk("mrst_good", snap_good, 0);
    chk("mrst_bytes", snap_good_bytes, 0);
    chk("mrst_done", 32'(frame_done), 0);
    chk("mrst_len", 32'(frame_len), 0);
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) cyc(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("mrst_nodone", 32'(frame_done), 0);
    end
    snap("s6", 1'b0, 0, 0, 0, 0, 0, 0);
    build(60, 1'b0); send(-1); expect_frame("post_rst", 0, 64);
    snap("s7", 1'b0, 1, 1, 0, 0, 0, 64);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
